vga_capture_rx: RTL and testbench
=================================

Name: vga_capture_rx

Overview:
Receive-side counterpart of the on-chip VGA timing/pixel generator. It samples the 8-bit TinyVGA PMOD byte, recovers horizontal and vertical timing from the active-high hsync/vsync pulses, and locks to the 640x480 frame. It then emits per-pixel coordinates and 6-bit colour, and reports sync errors. It sits in the bench/loopback path and in capture builds fed from the PMOD pins, running on the pixel clock.

Parameters:
H_DISPLAY, 640, active pixels per line
H_SYNC, 96, hsync pulse width (clocks)
H_BACK, 48, back porch (clocks)
H_TOTAL, 800, clocks per line
V_DISPLAY, 480, active lines per frame
V_SYNC, 2, vsync width (lines)
V_BACK, 33, vertical back porch (lines)
V_TOTAL, 525, lines per frame

Ports:
clk  in  1  pixel clock; one clock, all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
vga_in  in  8  {hsync,B0,G0,R0,vsync,B1,G1,R1}; sync is active-high
locked  out  1  1 while in LOCKED
sync_err  out  1  1-cycle pulse on any timing violation
err_count  out  8  count of sync_err pulses, saturates at 255
frame_start  out  1  1-cycle pulse on every vsync rise
pix_valid  out  1  active pixel present on pix_* (LOCKED only)
pix_x  out  10  0..639
pix_y  out  10  0..479
pix_rgb  out  6  {R1,R0,G1,G0,B1,B0}
frame_sum  out  16  checksum of last complete locked frame
frame_sum_valid  out  1  1-cycle pulse when frame_sum updates

Behaviour:
- Reset (async assert, sync-safe deassert): every output is 0; state is SEARCH; counters and flags are 0.
- Input stage: vga_in is registered into s1, and s1 into s2. A rise is detected when s1=1 and s2=0, separately for hsync and vsync.
- hc (10b):
  - 0 on the hsync-rise cycle, otherwise +1.
  - Saturates at 1023. Reaching 1023 is a timeout.
- vc (10b):
  - 0 on vsync rise.
  - +1 on each hsync rise, saturating at 1023.
  - If vsync and hsync rise together, vsync wins: vc=0 and hc=0.
- h_seen: set on the first hsync rise after reset or after any error.
- Line check: at an hsync rise with h_seen=1, the previous hc must equal H_TOTAL-1; otherwise it is an error.
- Frame check: at a vsync rise in MEASURE or LOCKED, vc must equal V_TOTAL; otherwise it is an error.
- FSM:
  - SEARCH -> MEASURE on vsync rise.
  - MEASURE -> LOCKED on the next vsync rise with no error.
  - MEASURE or LOCKED -> SEARCH on any error: line, frame or timeout.
  - An error pulses sync_err, increments err_count and clears h_seen. A timeout fires once per saturation.
  - Errors in SEARCH are not counted.
- frame_start pulses on every vsync rise, in any state.
- Active region: hc in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISPLAY-1] and vc in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISPLAY-1].
  - pix_x = hc-(H_SYNC+H_BACK); pix_y = vc-(V_SYNC+V_BACK).
  - pix_rgb is decoded from s1.
- Latency: vga_in sampled at edge k appears on pix_* after edge k+1, i.e. 2 cycles.
- pix_valid=0 outside LOCKED. pix_x, pix_y and pix_rgb hold their last values when pix_valid=0.
- Reset mid-frame returns to SEARCH immediately; relock needs 2 vsync rises.

Optional Feature:
VGA_RX_CHECKSUM_EN
- Defined:
  - A 16-bit accumulator adds zero-extended pix_rgb on every pix_valid cycle, wrapping mod 2^16.
  - On a vsync rise while LOCKED, the accumulator is copied to frame_sum and frame_sum_valid pulses.
  - The accumulator clears on every vsync rise and on error.
- Undefined: frame_sum=0 and frame_sum_valid=0 constantly; no accumulator is built.

Test Plan:
1. Reset, then drive the generator output with a black screen -> locked=0 through the first vsync rise. locked=1 after the second vsync rise. Exactly 307200 pix_valid cycles per locked frame; sync_err never asserted.
2. Generator colour = x[5:0] -> first pix_valid arrives 2 cycles after generator pixel (0,0) with pix_x=0, pix_y=0, pix_rgb=0. Last valid pixel has pix_x=639, pix_y=479, pix_rgb=6'h3F.
3. While locked, stretch one line to 801 clocks -> sync_err pulses once, err_count=1, locked=0. Relock after 2 further vsync rises.
4. While locked, hold hsync low 1100 clocks -> one sync_err when hc=1023, err_count+1, state SEARCH, pix_valid=0.
5. With VGA_RX_CHECKSUM_EN, constant colour 6'b000001 -> frame_sum=16'hB000 (307200 mod 65536) with a frame_sum_valid pulse. Without the macro -> frame_sum=0.
6. Assert rst_n=0 mid-frame for 3 cycles -> all outputs 0 immediately and err_count=0. Relock after 2 vsync rises.

Source files
------------

// File: rtl/vga_capture_rx_if.sv
`timescale 1ns/1ps
// Signal bundle between a TinyVGA PMOD byte source and the vga_capture_rx receiver.
// The master modport is the source/observer side; the slave modport is the receiver.
interface vga_capture_rx_if;
    logic [7:0]  vga_in;
    logic        locked;
    logic        sync_err;
    logic [7:0]  err_count;
    logic        frame_start;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [5:0]  pix_rgb;
    logic [15:0] frame_sum;
    logic        frame_sum_valid;

    modport master (
        output vga_in,
        input  locked, sync_err, err_count, frame_start, pix_valid,
        input  pix_x, pix_y, pix_rgb, frame_sum, frame_sum_valid
    );

    modport slave (
        input  vga_in,
        output locked, sync_err, err_count, frame_start, pix_valid,
        output pix_x, pix_y, pix_rgb, frame_sum, frame_sum_valid
    );
endinterface

// File: rtl/vga_capture_rx.sv
`timescale 1ns/1ps
// vga_capture_rx: recovers VGA line/frame timing from a TinyVGA PMOD byte and emits pixels.
// Define VGA_RX_CHECKSUM_EN to build the per-frame colour checksum (frame_sum).
module vga_capture_rx #(
    parameter int H_DISPLAY = 640,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int H_TOTAL   = 800,
    parameter int V_DISPLAY = 480,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int V_TOTAL   = 525
) (
    input  logic            clk,
    input  logic            rst_n,
    vga_capture_rx_if.slave bus
);

    localparam logic [9:0] CNT_MAX  = 10'd1023;
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_FULL   = 10'(V_TOTAL);
    localparam logic [9:0] H_ACT_LO = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_ACT_HI = 10'(H_SYNC + H_BACK + H_DISPLAY - 1);
    localparam logic [9:0] V_ACT_LO = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_ACT_HI = 10'(V_SYNC + V_BACK + V_DISPLAY - 1);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    logic [7:0] r_s1;
    logic [1:0] r_s2;  // {hsync, vsync} delayed one more cycle for edge detection
    logic [9:0] r_hc;
    logic [9:0] r_vc;
    logic       r_h_seen;
    state_t     r_state;
    logic       r_locked;
    logic       r_sync_err;
    logic [7:0] r_err_count;
    logic       r_frame_start;
    logic       r_pix_valid;
    logic [9:0] r_pix_x;
    logic [9:0] r_pix_y;
    logic [5:0] r_pix_rgb;

    logic       w_hs_rise;
    logic       w_vs_rise;
    logic [9:0] w_hc_inc;
    logic [9:0] w_hc_cur;
    logic [9:0] w_vc_inc;
    logic [9:0] w_vc_cur;
    logic       w_timeout;
    logic       w_line_err;
    logic       w_frame_err;
    logic       w_err_any;
    logic       w_err;
    logic       w_active;
    logic       w_pix_valid;
    logic [5:0] w_rgb;

    assign w_hs_rise = r_s1[7] & ~r_s2[1];
    assign w_vs_rise = r_s1[3] & ~r_s2[0];

    // w_hc_cur / w_vc_cur are the counts belonging to the byte currently held in r_s1.
    assign w_hc_inc = (r_hc == CNT_MAX) ? CNT_MAX : r_hc + 10'd1;
    assign w_hc_cur = w_hs_rise ? 10'd0 : w_hc_inc;
    assign w_vc_inc = (w_hs_rise && (r_vc != CNT_MAX)) ? r_vc + 10'd1 : r_vc;
    assign w_vc_cur = w_vs_rise ? 10'd0 : w_vc_inc;

    assign w_timeout   = (w_hc_cur == CNT_MAX) && (r_hc != CNT_MAX);
    assign w_line_err  = w_hs_rise && r_h_seen && (r_hc != H_LAST);
    assign w_frame_err = w_vs_rise && (r_state != ST_SEARCH) && (w_vc_inc != V_FULL);
    assign w_err_any   = w_timeout | w_line_err | w_frame_err;
    assign w_err       = w_err_any && (r_state != ST_SEARCH);

    assign w_active = (w_hc_cur >= H_ACT_LO) && (w_hc_cur <= H_ACT_HI) &&
                      (w_vc_cur >= V_ACT_LO) && (w_vc_cur <= V_ACT_HI);
    assign w_pix_valid = (r_state == ST_LOCKED) && !w_err && w_active;
    assign w_rgb = {r_s1[0], r_s1[4], r_s1[1], r_s1[5], r_s1[2], r_s1[6]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1          <= '0;
            r_s2          <= '0;
            r_hc          <= '0;
            r_vc          <= '0;
            r_h_seen      <= 1'b0;
            r_state       <= ST_SEARCH;
            r_locked      <= 1'b0;
            r_sync_err    <= 1'b0;
            r_err_count   <= '0;
            r_frame_start <= 1'b0;
            r_pix_valid   <= 1'b0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_pix_rgb     <= '0;
        end else begin
            // NOTE: every register here uses <= so all decisions see pre-edge values.
            r_s1 <= bus.vga_in;
            r_s2 <= {r_s1[7], r_s1[3]};
            r_hc <= w_hc_cur;
            r_vc <= w_vc_cur;

            if (w_err_any) begin
                r_h_seen <= 1'b0;
            end else if (w_hs_rise) begin
                r_h_seen <= 1'b1;
            end

            case (r_state)
                ST_SEARCH: begin
                    if (w_vs_rise) r_state <= ST_MEASURE;
                end
                ST_MEASURE: begin
                    if (w_err) begin
                        r_state <= ST_SEARCH;
                    end else if (w_vs_rise) begin
                        r_state  <= ST_LOCKED;
                        r_locked <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (w_err) begin
                        r_state  <= ST_SEARCH;
                        r_locked <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_SEARCH;
                    r_locked <= 1'b0;
                end
            endcase

            r_sync_err    <= w_err;
            r_frame_start <= w_vs_rise;
            if (w_err && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end

            r_pix_valid <= w_pix_valid;
            if (w_pix_valid) begin
                r_pix_x   <= w_hc_cur - H_ACT_LO;
                r_pix_y   <= w_vc_cur - V_ACT_LO;
                r_pix_rgb <= w_rgb;
            end
        end
    end

    assign bus.locked      = r_locked;
    assign bus.sync_err    = r_sync_err;
    assign bus.err_count   = r_err_count;
    assign bus.frame_start = r_frame_start;
    assign bus.pix_valid   = r_pix_valid;
    assign bus.pix_x       = r_pix_x;
    assign bus.pix_y       = r_pix_y;
    assign bus.pix_rgb     = r_pix_rgb;

`ifdef VGA_RX_CHECKSUM_EN
    logic [15:0] r_acc;
    logic [15:0] r_frame_sum;
    logic        r_frame_sum_valid;

    // Only a frame that was locked from its first to its last line publishes its sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc             <= '0;
            r_frame_sum       <= '0;
            r_frame_sum_valid <= 1'b0;
        end else begin
            r_frame_sum_valid <= 1'b0;
            if (w_vs_rise || w_err) begin
                if (w_vs_rise && (r_state == ST_LOCKED) && !w_err) begin
                    r_frame_sum       <= r_acc;
                    r_frame_sum_valid <= 1'b1;
                end
                r_acc <= '0;
            end else if (w_pix_valid) begin
                r_acc <= r_acc + {10'd0, w_rgb};
            end
        end
    end

    assign bus.frame_sum       = r_frame_sum;
    assign bus.frame_sum_valid = r_frame_sum_valid;
`else
    assign bus.frame_sum       = 16'd0;
    assign bus.frame_sum_valid = 1'b0;
`endif

endmodule

// File: tb/tb_vga_capture_rx.sv
`timescale 1ns/1ps
// Scoreboard bench for vga_capture_rx on a reduced 64x8 geometry: a frame generator pushes
// expected pixels/sums into queues, an independent monitor pops them when the DUT presents output.
module tb_vga_capture_rx;

    localparam int HD = 64;
    localparam int HS = 8;
    localparam int HB = 8;
    localparam int HT = 88;
    localparam int VD = 8;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int VT = 16;

    typedef struct {
        int          x;
        int          y;
        logic [5:0]  rgb;
        longint      cyc;
    } pix_t;

    logic   clk = 1'b0;
    logic   rst_n;
    longint cyc = 0;

    pix_t        sb[$];
    logic [15:0] sum_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_pix    = 0;
    int n_err_pulse = 0;
    int n_fs     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vga_capture_rx_if vif ();

    vga_capture_rx #(
        .H_DISPLAY(HD), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
        .V_DISPLAY(VD), .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (vif)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_locked"},      vif.locked, 0);
        check({tag, "_sync_err"},    vif.sync_err, 0);
        check({tag, "_err_count"},   vif.err_count, 0);
        check({tag, "_frame_start"}, vif.frame_start, 0);
        check({tag, "_pix_valid"},   vif.pix_valid, 0);
        check({tag, "_pix_x"},       vif.pix_x, 0);
        check({tag, "_pix_y"},       vif.pix_y, 0);
        check({tag, "_pix_rgb"},     vif.pix_rgb, 0);
        check({tag, "_frame_sum"},   vif.frame_sum, 0);
        check({tag, "_sum_valid"},   vif.frame_sum_valid, 0);
    endtask

    // Byte layout {hsync,B0,G0,R0,vsync,B1,G1,R1}; rgb argument is {R1,R0,G1,G0,B1,B0}.
    task automatic drive(input bit hs, input bit vs, input logic [5:0] rgb);
        vif.vga_in = {hs, rgb[0], rgb[2], rgb[4], vs, rgb[1], rgb[3], rgb[5]};
    endtask

    // colour: 0 black, 1 pixel x[5:0], 2 constant 6'b000001.
    // ext_line gets ext_clks extra blank clocks; rst_line pulses reset for 3 clocks at h=20.
    task automatic gen_frame(input int colour, input bit exp_lock, input int ext_line,
                             input int ext_clks, input int rst_line, input bit push_sum,
                             input logic [15:0] sum_val);
        bit         lk;
        bit         full;
        bit         act;
        int         seen0;
        int         len;
        logic [5:0] rgb;
        pix_t       e;
        lk    = exp_lock;
        full  = exp_lock && (ext_clks == 0) && (rst_line < 0);
        seen0 = n_pix;
        for (int v = 0; v < VT; v++) begin
            len = HT + ((v == ext_line) ? ext_clks : 0);
            for (int h = 0; h < len; h++) begin
                @(posedge clk);
                #1;
`ifdef VGA_RX_CHECKSUM_EN
                if ((v == 0) && (h == 0) && push_sum) sum_q.push_back(sum_val);
`endif
                if ((v == rst_line) && (h == 20)) begin
                    rst_n = 1'b0;
                    lk    = 1'b0;
                    #1;
                    check_all_zero("midreset");
                end
                if ((v == rst_line) && (h == 23)) rst_n = 1'b1;
                act = (h >= HS + HB) && (h < HS + HB + HD) && (v >= VS + VB) && (v < VS + VB + VD);
                rgb = 6'd0;
                if (act && (colour == 1)) rgb = 6'(h - HS - HB);
                if (act && (colour == 2)) rgb = 6'd1;
                drive(h < HS, v < VS, rgb);
                if (act && lk) begin
                    e.x   = h - HS - HB;
                    e.y   = v - VS - VB;
                    e.rgb = rgb;
                    e.cyc = cyc;
                    sb.push_back(e);
                end
                if ((v == VS + VB + VD / 2) && (h == 0)) check("locked_mid", vif.locked, lk);
            end
            if ((v == ext_line) && (ext_clks > 0)) lk = 1'b0;
        end
        check("sb_drained", sb.size(), 0);
        if (full) check("pix_per_frame", n_pix - seen0, HD * VD);
    endtask

    initial begin : monitor
        pix_t e;
        forever begin
            @(negedge clk);
            if (vif.sync_err)    n_err_pulse++;
            if (vif.frame_start) n_fs++;
            if (vif.pix_valid) begin
                n_pix++;
                if (sb.size() == 0) begin
                    check("pix_unexpected_valid", vif.pix_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check("pix_x",       vif.pix_x, e.x);
                    check("pix_y",       vif.pix_y, e.y);
                    check("pix_rgb",     vif.pix_rgb, e.rgb);
                    check("pix_latency", cyc - e.cyc, 2);
                end
            end
            if (vif.frame_sum_valid) begin
                if (sum_q.size() == 0) check("sum_unexpected_pulse", vif.frame_sum_valid, 0);
                else check("frame_sum", vif.frame_sum, sum_q.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 6'd0);
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Lock acquisition on a black screen.
        gen_frame(0, 1'b0, -1, 0, -1, 1'b0, 16'h0000);
        check("f0_no_err", n_err_pulse, 0);
        gen_frame(0, 1'b1, -1, 0, -1, 1'b0, 16'h0000);
        check("f1_no_err", n_err_pulse, 0);
        // Colour ramp: first pixel rgb 0, last pixel (63,7) rgb 3F; sum 8*2016 = 0x3F00.
        gen_frame(1, 1'b1, -1, 0, -1, 1'b1, 16'h0000);
        // Line 6 stretched by one clock.
        gen_frame(1, 1'b1, 6, 1, -1, 1'b1, 16'h3F00);
        check("stretch_err_count", vif.err_count, 1);
        check("stretch_err_pulses", n_err_pulse, 1);
        check("stretch_unlocked", vif.locked, 0);
        gen_frame(0, 1'b0, -1, 0, -1, 1'b0, 16'h0000);
        gen_frame(0, 1'b1, -1, 0, -1, 1'b0, 16'h0000);
        check("relock1", vif.locked, 1);
        // hsync held low for 1100 extra clocks after line 6.
        gen_frame(0, 1'b1, 6, 1100, -1, 1'b1, 16'h0000);
        check("timeout_err_count", vif.err_count, 2);
        check("timeout_err_pulses", n_err_pulse, 2);
        check("timeout_unlocked", vif.locked, 0);
        check("timeout_no_pix", vif.pix_valid, 0);
        // Constant colour 1: each locked frame sums to 512 = 0x0200.
        gen_frame(2, 1'b0, -1, 0, -1, 1'b0, 16'h0000);
        gen_frame(2, 1'b1, -1, 0, -1, 1'b0, 16'h0000);
        gen_frame(2, 1'b1, -1, 0, -1, 1'b1, 16'h0200);
        // Reset pulsed on line 2, then relock.
        gen_frame(0, 1'b1, -1, 0, 2, 1'b1, 16'h0200);
        check("post_reset_err_count", vif.err_count, 0);
        gen_frame(0, 1'b0, -1, 0, -1, 1'b0, 16'h0000);
        gen_frame(0, 1'b1, -1, 0, -1, 1'b0, 16'h0000);
        check("relock2", vif.locked, 1);

        repeat (5) @(posedge clk);
        #1;
        check("final_err_pulses", n_err_pulse, 2);
        check("final_err_count", vif.err_count, 0);
        check("frame_start_count", n_fs, 13);
        check("sum_queue_drained", sum_q.size(), 0);
`ifndef VGA_RX_CHECKSUM_EN
        check("frame_sum_disabled", vif.frame_sum, 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
